fft_scale_stream: RTL and testbench
===================================

Name: fft_scale_stream

Overview:
- Streaming successor to the combinational divide-by-N array scaler.
- Accepts one complex sample per cycle on a valid/ready stream, framed by in_last.
- Scales each sample by 1/N: arithmetic shift when N is a power of two, rounded reciprocal multiply otherwise.
- Sits after the IFFT output reorder stage; adds round-half-up, a per-frame bypass mode, frame-length checking and backpressure.

Parameters:
- N, 8, FFT points per frame; N >= 1; sets scale factor and frame length.
- W, 15, MSB index of each real/imag component; data width is W+1, two's complement.
- BIT_FRAC, 15, fractional bits of the reciprocal constant INV_N.
- ROUND, 1, 1 = round half up (add half LSB, then shift); 0 = truncate (floor).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_re  in  W+1  real component, signed.
- in_im  in  W+1  imaginary component, signed.
- in_last  in  1  last sample of the frame.
- mode  in  1  0 = bypass, 1 = divide by N; sampled on the first sample of each frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_re  out  W+1  scaled real component.
- out_im  out  W+1  scaled imaginary component.
- out_last  out  1  in_last delayed with its sample.
- frame_err  out  1  one-cycle pulse on a frame-length violation.

Behaviour:
- Reset (async, rst_n low): s1_valid, s2_valid, out_valid, out_last and frame_err = 0; out_re/out_im = 0; sample counter = 0; mode_q = 0. in_ready = 1 while reset is deasserted and the pipe is empty.
- Pipeline: 2 stages, S1 then S2.
  - S1 registers the product (reciprocal path) or the sign-extended input (shift path), plus last and mode_q.
  - S2 applies rounding, shift, truncation to W+1 and registers out_*.
  - Latency is 2 cycles from in handshake to out_valid when out_ready stays 1. Throughput is 1 sample/cycle.
- Stall: stall = out_valid && !out_ready. When stall is high, both stages hold and in_ready = 0. Otherwise stages advance and in_ready = 1. in_ready depends combinationally on out_ready.
- Handshake: transfer occurs on in_valid && in_ready. Output data is stable while out_valid && !out_ready. A bubble (in_valid = 0) propagates as an invalid stage.
- Shift path (N a power of two, P = log2 N):
  - y = (x + (ROUND ? 2^(P-1) : 0)) >>> P, with an internal W+2-bit sum.
  - N = 1 gives y = x.
- Reciprocal path (otherwise):
  - INV_N = round(2^BIT_FRAC / N), an elaboration-time constant.
  - Product width 2(W+1)+1.
  - y = (x*INV_N + (ROUND ? 2^(BIT_FRAC-1) : 0)) >>> BIT_FRAC, truncated to W+1.
  - Overflow is impossible for N >= 2; assert it in simulation.
- Bypass (mode_q = 0): y = x, with the same 2-cycle latency.
- Mode latch: mode is captured into mode_q on the accepted sample where count == 0. mode_q applies to that whole frame; mid-frame changes are ignored.
- Frame counter: counts accepted samples, range 0..N-1.
  - in_last with count == N-1: counter returns to 0, no error.
  - in_last with count != N-1: frame_err pulses, counter returns to 0.
  - count == N-1 without in_last: frame_err pulses, counter wraps to 0 and the next sample starts a new frame.
  - Data is always passed through; errors only flag.
- frame_err timing: pulses the cycle after the offending accept and is independent of output stall.
- Reset mid-frame or mid-stall: all in-flight samples are discarded, with no out_valid after reset.

Decomposition:
- Package fft_pkg holds:
  - typedef cplx_t (packed struct re/im, W+1 each, parametrised via the module).
  - function is_pow2(int).
  - function inv_n(N, BIT_FRAC) returning the rounded reciprocal.
  - localparam helpers for log2.
- One sub-module, fft_round_shift: parameters IN_W, SHIFT, ROUND, OUT_W; pure combinational round-and-shift. It is instantiated twice (re, im) in S2 and reused by both paths.

Test Plan:
- N=8, W=15, ROUND=1, mode=1; stream re=100, im=-100, then 6 samples of 0 plus last -> out_re=13, out_im=-12, out_last on sample 8, frame_err=0, latency 2.
- Same stimulus with ROUND=0 -> out_re=12, out_im=-13.
- N=6, BIT_FRAC=15 (INV_N=5461), mode=1; re=600, im=-32768 -> out_re=100, out_im=-5461.
- N=8, mode=0 for frame 1 and mode toggled to 1 mid-frame -> frame 1 fully bypassed (re=100 -> 100); frame 2 with mode=1 -> 13.
- N=8; hold out_ready=0 for 5 cycles during a 10-sample back-to-back burst -> in_ready=0 while stalled, no sample lost or duplicated, order preserved.
- N=8; in_last on sample 5, then 9 samples with no last -> frame_err pulses after sample 5 and after sample 8 of the next frame. Then assert rst_n=0 mid-burst -> out_valid=0 immediately and no stale output after release.

Source files
------------

// File: rtl/fft_scale_stream_pkg.sv
// Shared types and elaboration-time helpers for the streaming 1/N scaler.
package fft_pkg;

    localparam int unsigned CPLX_W = 16;

    // Complex sample at the default component width.
    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // True when n is a nonzero power of two.
    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    // floor(log2(n)) for n >= 1.
    function automatic int unsigned log2_floor(input int unsigned n);
        int unsigned r = 0;
        int unsigned v = n;
        while (v > 1) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    // round(2^bit_frac / n), half rounded up.
    function automatic int unsigned inv_n(input int unsigned n, input int unsigned bit_frac);
        return ((32'd1 << bit_frac) + n / 2) / n;
    endfunction

endpackage

// File: rtl/fft_scale_stream_if.sv
// Sample stream into and out of the scaler, plus the frame-error flag.
interface fft_scale_stream_if #(
    parameter int unsigned W = 15
);
    logic              in_valid;
    logic              in_ready;
    logic signed [W:0] in_re;
    logic signed [W:0] in_im;
    logic              in_last;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic signed [W:0] out_re;
    logic signed [W:0] out_im;
    logic              out_last;
    logic              frame_err;

    modport slave (
        input  in_valid, in_re, in_im, in_last, mode, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last, frame_err
    );

    modport master (
        output in_valid, in_re, in_im, in_last, mode, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last, frame_err
    );
endinterface

// File: rtl/fft_scale_stream_round_shift.sv
// Combinational round-half-up (or floor) arithmetic right shift with width reduction.
module fft_round_shift #(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned SHIFT = 3,
    parameter int unsigned ROUND = 1,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout_c,
    output logic                    ovf_c
);

    localparam logic signed [IN_W-1:0] HALF = (ROUND != 0) ? IN_W'((2 ** SHIFT) / 2) : '0;

    logic signed [IN_W-1:0] sum_c;
    logic signed [IN_W-1:0] shr_c;

    // Add half an output LSB, shift, and flag results that do not fit OUT_W.
    always_comb begin
        sum_c  = din + HALF;
        shr_c  = sum_c >>> SHIFT;
        dout_c = OUT_W'(shr_c);
        ovf_c  = (shr_c != IN_W'(dout_c));
    end

endmodule

// File: rtl/fft_scale_stream.sv
// Streaming 1/N scaler for IFFT output: two-stage pipe, per-frame bypass, frame-length check.
module fft_scale_stream
    import fft_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned W        = 15,
    parameter int unsigned BIT_FRAC = 15,
    parameter int unsigned ROUND    = 1
) (
    input logic                clk,
    input logic                rst_n,
    fft_scale_stream_if.slave  bus
);

    localparam bit          IS_POW2 = is_pow2(N);
    localparam int unsigned SHIFT   = IS_POW2 ? log2_floor(N) : BIT_FRAC;
    localparam int unsigned DW      = W + 1;
    localparam int unsigned PW      = 2 * DW + 1;
    localparam int unsigned S1_W    = IS_POW2 ? DW + 1 : PW;
    localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(N - 1);
    localparam logic signed [PW-1:0] INV_C   = PW'(inv_n(N, BIT_FRAC));

    logic stall_c, adv_c, acc_c, first_c, at_end_c, eff_mode_c;
    logic signed [PW-1:0] re_ext_c, im_ext_c, re_prod_c, im_prod_c;
    logic signed [DW-1:0] rs_re_c, rs_im_c;
    logic ovf_re_c, ovf_im_c;

    logic                   s1_valid_d, s1_valid_q, s1_last_d, s1_last_q, s1_mode_d, s1_mode_q;
    logic signed [S1_W-1:0] s1_re_d, s1_re_q, s1_im_d, s1_im_q;
    logic                   out_valid_d, out_valid_q, out_last_d, out_last_q;
    logic                   frame_err_d, frame_err_q, mode_d, mode_q;
    logic signed [DW-1:0]   out_re_d, out_re_q, out_im_d, out_im_q;
    logic [CNT_W-1:0]       count_d, count_q;

    // Handshake, frame tracking and next-state for both pipeline stages.
    always_comb begin
        stall_c    = out_valid_q && !bus.out_ready;
        adv_c      = !stall_c;
        acc_c      = bus.in_valid && adv_c;
        first_c    = (count_q == '0);
        at_end_c   = (count_q == CNT_MAX);
        eff_mode_c = first_c ? bus.mode : mode_q;
        re_ext_c   = PW'(bus.in_re);
        im_ext_c   = PW'(bus.in_im);
        re_prod_c  = re_ext_c * INV_C;
        im_prod_c  = im_ext_c * INV_C;

        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_mode_d   = s1_mode_q;
        s1_re_d     = s1_re_q;
        s1_im_d     = s1_im_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        count_d     = count_q;
        mode_d      = mode_q;
        frame_err_d = acc_c && (bus.in_last != at_end_c);

        if (acc_c) begin
            if (first_c) begin
                mode_d = bus.mode;
            end
            if (bus.in_last || at_end_c) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (adv_c) begin
            s1_valid_d = acc_c;
            if (acc_c) begin
                s1_last_d = bus.in_last;
                s1_mode_d = eff_mode_c;
                if (eff_mode_c && !IS_POW2) begin
                    s1_re_d = S1_W'(re_prod_c);
                    s1_im_d = S1_W'(im_prod_c);
                end else begin
                    s1_re_d = S1_W'(re_ext_c);
                    s1_im_d = S1_W'(im_ext_c);
                end
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_last_d = s1_last_q;
                out_re_d   = s1_mode_q ? rs_re_c : DW'(s1_re_q);
                out_im_d   = s1_mode_q ? rs_im_c : DW'(s1_im_q);
            end
        end
    end

    // Pipeline, counter and mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            count_q     <= '0;
            mode_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_mode_q   <= s1_mode_d;
            s1_re_q     <= s1_re_d;
            s1_im_q     <= s1_im_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            frame_err_q <= frame_err_d;
        end
    end

    fft_round_shift #(.IN_W(S1_W), .SHIFT(SHIFT), .ROUND(ROUND), .OUT_W(DW)) u_rs_re (
        .din    (s1_re_q),
        .dout_c (rs_re_c),
        .ovf_c  (ovf_re_c)
    );

    fft_round_shift #(.IN_W(S1_W), .SHIFT(SHIFT), .ROUND(ROUND), .OUT_W(DW)) u_rs_im (
        .din    (s1_im_q),
        .dout_c (rs_im_c),
        .ovf_c  (ovf_im_c)
    );

    // Scaling by 1/N can never leave the W+1 range.
    a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        (s1_valid_q && s1_mode_q) |-> !(ovf_re_c || ovf_im_c));

    assign bus.in_ready  = adv_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_scale_stream.sv
// Bench: three scaler configurations (N=8 round, N=8 floor, N=6 reciprocal) on one shared stream.
module tb_fft_scale_stream;
    import fft_pkg::*;

    localparam int unsigned W  = 15;
    localparam int          BF = 15;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  in_valid, in_last, mode, out_ready;
    cplx_t in_s;

    always #5 clk = ~clk;

    fft_scale_stream_if #(.W(W)) bus0 ();
    fft_scale_stream_if #(.W(W)) bus1 ();
    fft_scale_stream_if #(.W(W)) bus2 ();

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
    assign bus0.in_re = in_s.re;      assign bus1.in_re = in_s.re;      assign bus2.in_re = in_s.re;
    assign bus0.in_im = in_s.im;      assign bus1.in_im = in_s.im;      assign bus2.in_im = in_s.im;
    assign bus0.in_last = in_last;    assign bus1.in_last = in_last;    assign bus2.in_last = in_last;
    assign bus0.mode = mode;          assign bus1.mode = mode;          assign bus2.mode = mode;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;

    fft_scale_stream #(.N(8), .W(W), .BIT_FRAC(BF), .ROUND(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fft_scale_stream #(.N(8), .W(W), .BIT_FRAC(BF), .ROUND(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fft_scale_stream #(.N(6), .W(W), .BIT_FRAC(BF), .ROUND(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [2:0]        ov, ir, ol, fe;
    logic signed [15:0] ore [3];
    logic signed [15:0] oim [3];
    assign ov = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign ir = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
    assign ol = {bus2.out_last, bus1.out_last, bus0.out_last};
    assign fe = {bus2.frame_err, bus1.frame_err, bus0.frame_err};
    assign ore[0] = bus0.out_re; assign ore[1] = bus1.out_re; assign ore[2] = bus2.out_re;
    assign oim[0] = bus0.out_im; assign oim[1] = bus1.out_im; assign oim[2] = bus2.out_im;

    // Reference model state: frame position, latched mode, pending error, expected outputs.
    int          cnt [3];
    logic        mq  [3];
    logic [2:0]  err_pend;
    logic [32:0] q0[$], q1[$], q2[$];
    int          checks = 0;
    int          errors = 0;
    logic        last_acc;

    function automatic int dut_n(input int d);
        return (d == 2) ? 6 : 8;
    endfunction

    function automatic int dut_rnd(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    function automatic longint floordiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // y = floor((x + rounding) / N), either directly or via the rounded reciprocal.
    function automatic logic signed [15:0] ref_scale(input int n, input int rnd, input logic md,
                                                     input logic signed [15:0] x);
        longint num, den, inv;
        if (!md) return x;
        if ((n & (n - 1)) == 0) begin
            num = longint'(x) + ((rnd != 0) ? longint'(n / 2) : 64'sd0);
            den = n;
        end else begin
            inv = ((64'sd1 <<< BF) + n / 2) / n;
            num = longint'(x) * inv + ((rnd != 0) ? (64'sd1 <<< (BF - 1)) : 64'sd0);
            den = 64'sd1 <<< BF;
        end
        return 16'(floordiv(num, den));
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic q_push(input int d, input logic [32:0] v);
        case (d)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int q_size(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_pop(input int d, output logic [32:0] v);
        case (d)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0;
            mq[d]  = 1'b0;
        end
        err_pend = '0;
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Check outputs and frame_err, then feed this cycle's accepted sample to the model.
    task automatic monitor();
        logic [32:0] e;
        logic first, at_end, m;
        logic signed [15:0] yr, yi;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("frame_err[%0d]", d), fe[d], err_pend[d]);
            if (ov[d] && out_ready) begin
                if (q_size(d) == 0) begin
                    chk($sformatf("stale_out[%0d]", d), ov[d], 1'b0);
                end else begin
                    q_pop(d, e);
                    chk($sformatf("out_re[%0d]", d), ore[d], $signed(e[31:16]));
                    chk($sformatf("out_im[%0d]", d), oim[d], $signed(e[15:0]));
                    chk($sformatf("out_last[%0d]", d), ol[d], e[32]);
                end
            end
            if (in_valid && ir[d]) begin
                first  = (cnt[d] == 0);
                at_end = (cnt[d] == dut_n(d) - 1);
                m      = first ? mode : mq[d];
                if (first) mq[d] = mode;
                err_pend[d] = in_last ^ at_end;
                cnt[d] = (in_last || at_end) ? 0 : cnt[d] + 1;
                yr = ref_scale(dut_n(d), dut_rnd(d), m, in_s.re);
                yi = ref_scale(dut_n(d), dut_rnd(d), m, in_s.im);
                q_push(d, {in_last, yr, yi});
            end else begin
                err_pend[d] = 1'b0;
            end
        end
        last_acc = in_valid && ir[0];
    endtask

    task automatic tick();
        #1;
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic signed [15:0] re, input logic signed [15:0] im,
                        input logic last, input logic md);
        int n;
        in_valid = 1'b1;
        in_s.re  = re;
        in_s.im  = im;
        in_last  = last;
        mode     = md;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("send_timeout", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic send_zeros(input int count, input logic md);
        for (int i = 0; i < count; i++) send(16'sd0, 16'sd0, (i == count - 1), md);
    endtask

    initial begin
        int idx;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b1;
        in_s = '0;
        last_acc = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), ov[d], 1'b0);
            chk($sformatf("rst_out_re[%0d]", d), ore[d], 0);
            chk($sformatf("rst_out_im[%0d]", d), oim[d], 0);
            chk($sformatf("rst_out_last[%0d]", d), ol[d], 1'b0);
            chk($sformatf("rst_frame_err[%0d]", d), fe[d], 1'b0);
            chk($sformatf("rst_in_ready[%0d]", d), ir[d], 1'b1);
        end
        rst_n = 1'b1;
        idle(3);

        // Divide by 8, rounded and floored, with a two-cycle latency.
        send(16'sd100, -16'sd100, 1'b0, 1'b1);
        chk("latency_not_1", ov[0], 1'b0);
        send(16'sd0, 16'sd0, 1'b0, 1'b1);
        chk("latency_2", ov[0], 1'b1);
        chk("round_re", ore[0], 13);
        chk("round_im", oim[0], -12);
        chk("floor_re", ore[1], 12);
        chk("floor_im", oim[1], -13);
        send_zeros(6, 1'b1);
        tick();
        chk("last_on_8", ol[0], 1'b1);
        chk("no_err_frame8", fe[0], 1'b0);
        idle(3);

        // Reciprocal path for N=6.
        send(16'sd600, -16'sd32768, 1'b0, 1'b1);
        send(16'sd0, 16'sd0, 1'b0, 1'b1);
        chk("recip_re", ore[2], 100);
        chk("recip_im", oim[2], -5461);
        send_zeros(6, 1'b1);
        idle(3);

        // Mode latched at frame start; mid-frame changes ignored.
        send(16'sd100, 16'sd0, 1'b0, 1'b0);
        send(16'sd0, 16'sd0, 1'b0, 1'b1);
        chk("bypass_re", ore[0], 100);
        send_zeros(6, 1'b1);
        send(16'sd100, 16'sd0, 1'b0, 1'b1);
        send(16'sd0, 16'sd0, 1'b0, 1'b0);
        chk("mode_frame2_re", ore[0], 13);
        send_zeros(6, 1'b0);
        idle(3);

        // Back-to-back burst with a five-cycle downstream stall.
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 40) begin
            out_ready = !(cyc >= 5 && cyc < 10);
            in_valid  = 1'b1;
            in_s.re   = 16'(idx * 37 - 100);
            in_s.im   = 16'(1000 - idx * 3);
            in_last   = (idx == 9);
            mode      = 1'b1;
            tick();
            if (last_acc) idx++;
            if (cyc >= 5 && cyc < 10) chk("stall_in_ready", ir[0], 1'b0);
            cyc++;
        end
        chk("burst_count", idx, 10);
        out_ready = 1'b1;
        idle(4);

        // Short frame, then an over-long frame.
        for (int i = 0; i < 5; i++) begin
            send(16'(i), 16'(i), (i == 4), 1'b1);
            if (i == 3) chk("err_before_short", fe[0], 1'b0);
        end
        chk("err_short", fe[0], 1'b1);
        for (int i = 0; i < 9; i++) begin
            send(16'(i * 5), 16'(-i), 1'b0, 1'b1);
            if (i == 6) chk("err_mid_long", fe[0], 1'b0);
            if (i == 7) chk("err_long", fe[0], 1'b1);
            if (i == 8) chk("err_after_wrap", fe[0], 1'b0);
        end

        // Reset in the middle of a burst discards everything in flight.
        in_valid = 1'b1;
        in_s.re  = 16'sd77;
        in_s.im  = -16'sd77;
        in_last  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("rst_mid_out_valid[%0d]", d), ov[d], 1'b0);
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk("no_stale_after_rst", ov[0], 1'b0);

        // Randomized traffic with random framing, mode, valid and ready.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       in_s.re = -16'sd32768;
                1:       in_s.re = 16'sd32767;
                default: in_s.re = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       in_s.im = -16'sd32768;
                1:       in_s.im = 16'sd32767;
                default: in_s.im = 16'($urandom);
            endcase
            in_last = ($urandom_range(0, 7) == 0);
            mode    = 1'($urandom_range(0, 1));
            tick();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
            tick();
        end
        for (int d = 0; d < 3; d++) chk($sformatf("drained[%0d]", d), q_size(d), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
